// File: rtl/zvc_decompressor.sv
// Zero-value decompressor: scatters packed nonzero words back to their mask slots over a 2-stage pipeline.
// Optional macro ZVD_NNZ_CHECK_EN adds a sticky check of in_nnz against popcount(in_mask).
module zvc_decompressor #(
  parameter int WORD_WIDTH    = 8,
  parameter int LINE_SIZE     = 128,
  parameter int DIST_WIDTH    = 7,
  parameter int MAX_LIFM_RSIZ = 4,
  parameter int CNT_W         = $clog2(LINE_SIZE) + 1
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [LINE_SIZE-1:0]                          in_mask,
  input  logic [LINE_SIZE*WORD_WIDTH-1:0]               in_lifm,
  input  logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] in_mt,
  input  logic [CNT_W-1:0]                              in_nnz,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [LINE_SIZE*WORD_WIDTH-1:0]               out_lifm,
  output logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] out_mt,
  output logic [CNT_W-1:0]                              out_nnz,
  output logic                                          err_nnz
);
  localparam int MT_W  = DIST_WIDTH * MAX_LIFM_RSIZ;
  localparam int IDX_W = $clog2(LINE_SIZE);

  logic                            s1_valid_q;
  logic [LINE_SIZE-1:0]            s1_mask_q;
  logic [LINE_SIZE*WORD_WIDTH-1:0] s1_lifm_q;
  logic [LINE_SIZE*MT_W-1:0]       s1_mt_q;
  logic [LINE_SIZE*IDX_W-1:0]      s1_pfx_q;
  logic [CNT_W-1:0]                s1_nnz_q;
  logic                            out_valid_q;
  logic [LINE_SIZE*WORD_WIDTH-1:0] out_lifm_q;
  logic [LINE_SIZE*MT_W-1:0]       out_mt_q;
  logic [CNT_W-1:0]                out_nnz_q;

  logic [LINE_SIZE*IDX_W-1:0]      pfx_d;
  logic [CNT_W-1:0]                nnz_d;
  logic [LINE_SIZE*WORD_WIDTH-1:0] out_lifm_d;
  logic [LINE_SIZE*MT_W-1:0]       out_mt_d;
  logic                            s2_adv_s;
  logic                            s1_adv_s;
  logic                            in_xfer_s;

  assign s2_adv_s  = !out_valid_q || out_ready;
  assign s1_adv_s  = !s1_valid_q || s2_adv_s;
  assign in_ready  = s1_adv_s;
  assign in_xfer_s = in_valid && s1_adv_s;

  assign out_valid = out_valid_q;
  assign out_lifm  = out_lifm_q;
  assign out_mt    = out_mt_q;
  assign out_nnz   = out_nnz_q;

  // Exclusive prefix popcount of the mask; a slot's prefix is its source index in the packed line.
  always_comb begin
    logic [CNT_W-1:0] acc;
    acc   = '0;
    pfx_d = '0;
    for (int i = 0; i < LINE_SIZE; i++) begin
      pfx_d[i*IDX_W +: IDX_W] = acc[IDX_W-1:0];
      acc = acc + {{(CNT_W-1){1'b0}}, in_mask[i]};
    end
    nnz_d = acc;
  end

  // Scatter packed words to their slots; empty slots are zero-filled.
  always_comb begin
    logic [IDX_W-1:0] idx;
    out_lifm_d = '0;
    out_mt_d   = '0;
    for (int i = 0; i < LINE_SIZE; i++) begin
      idx = s1_pfx_q[i*IDX_W +: IDX_W];
      if (s1_mask_q[i]) begin
        out_lifm_d[i*WORD_WIDTH +: WORD_WIDTH] = s1_lifm_q[int'(idx)*WORD_WIDTH +: WORD_WIDTH];
        out_mt_d[i*MT_W +: MT_W]               = s1_mt_q[int'(idx)*MT_W +: MT_W];
      end else begin
        out_lifm_d[i*WORD_WIDTH +: WORD_WIDTH] = '0;
        out_mt_d[i*MT_W +: MT_W]               = '0;
      end
    end
  end

  // Pipeline registers: each stage loads only when it advances, so a stalled output holds still.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_mask_q   <= '0;
      s1_lifm_q   <= '0;
      s1_mt_q     <= '0;
      s1_pfx_q    <= '0;
      s1_nnz_q    <= '0;
      out_valid_q <= 1'b0;
      out_lifm_q  <= '0;
      out_mt_q    <= '0;
      out_nnz_q   <= '0;
    end else begin
      if (s1_adv_s) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_mask_q <= in_mask;
          s1_lifm_q <= in_lifm;
          s1_mt_q   <= in_mt;
          s1_pfx_q  <= pfx_d;
          s1_nnz_q  <= nnz_d;
        end
      end
      if (s2_adv_s) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_lifm_q <= out_lifm_d;
          out_mt_q   <= out_mt_d;
          out_nnz_q  <= s1_nnz_q;
        end
      end
    end
  end

`ifdef ZVD_NNZ_CHECK_EN
  logic err_nnz_q;

  // Sticky flag: producer's declared count disagreed with the mask on some accepted line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_nnz_q <= 1'b0;
    end else if (in_xfer_s && (in_nnz != nnz_d)) begin
      err_nnz_q <= 1'b1;
    end
  end

  assign err_nnz = err_nnz_q;
`else
  logic unused_nnz_s;
  assign unused_nnz_s = ^{in_nnz, in_xfer_s};
  assign err_nnz      = 1'b0;
`endif

endmodule

// File: tb/tb_zvc_decompressor.sv
// Randomized bench for zvc_decompressor: a queue-based line model checks every output transfer.
module tb_zvc_decompressor;
  localparam int W   = 8;
  localparam int L   = 128;
  localparam int DW  = 7;
  localparam int R   = 4;
  localparam int MTW = DW * R;
  localparam int CW  = 8;
`ifdef ZVD_NNZ_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic [L-1:0]       in_mask;
  logic [L*W-1:0]     in_lifm;
  logic [L*MTW-1:0]   in_mt;
  logic [CW-1:0]      in_nnz;
  logic               out_valid;
  logic               out_ready;
  logic [L*W-1:0]     out_lifm;
  logic [L*MTW-1:0]   out_mt;
  logic [CW-1:0]      out_nnz;
  logic               err_nnz;

  always #5 clk = ~clk;

  zvc_decompressor #(.WORD_WIDTH(W), .LINE_SIZE(L), .DIST_WIDTH(DW), .MAX_LIFM_RSIZ(R), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mask(in_mask), .in_lifm(in_lifm), .in_mt(in_mt), .in_nnz(in_nnz),
    .out_valid(out_valid), .out_ready(out_ready), .out_lifm(out_lifm),
    .out_mt(out_mt), .out_nnz(out_nnz), .err_nnz(err_nnz)
  );

  typedef struct {
    logic [L*W-1:0]   lifm;
    logic [L*MTW-1:0] mt;
    logic [CW-1:0]    nnz;
  } line_t;

  line_t          exp_q[$];
  int             n_cmp = 0;
  int             n_bad = 0;
  bit             err_exp = 1'b0;
  bit             hold_v = 1'b0;
  logic [L*W-1:0] hold_lifm;
  int             last_wait;

  function automatic logic [31:0] fold(input logic [4095:0] v);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < 128; i++) f = f ^ v[i*32 +: 32];
    return f;
  endfunction

  task automatic check(input string tag, input logic [4095:0] obs, input logic [4095:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got low=%h sig=%h, want low=%h sig=%h",
               tag, obs[127:0], fold(obs), exp[127:0], fold(exp));
    end
  endtask

  // Reference: walk slots in order, handing out packed words one by one to set mask bits.
  function automatic line_t expand(input logic [L-1:0] m, input logic [L*W-1:0] lf,
                                   input logic [L*MTW-1:0] mt);
    line_t r;
    int    k;
    r.lifm = '0;
    r.mt   = '0;
    k      = 0;
    for (int i = 0; i < L; i++) begin
      if (m[i]) begin
        r.lifm[i*W +: W]     = lf[k*W +: W];
        r.mt[i*MTW +: MTW]   = mt[k*MTW +: MTW];
        k++;
      end
    end
    r.nnz = CW'(k);
    return r;
  endfunction

  task automatic rand_line();
    int mode;
    mode = $urandom_range(0, 2);
    for (int i = 0; i < L / 32; i++) begin
      case (mode)
        0: in_mask[i*32 +: 32] = $urandom;
        1: in_mask[i*32 +: 32] = $urandom & $urandom & $urandom;
        default: in_mask[i*32 +: 32] = $urandom | $urandom;
      endcase
    end
    for (int i = 0; i < L * W / 32; i++) in_lifm[i*32 +: 32] = $urandom;
    for (int i = 0; i < L * MTW / 32; i++) in_mt[i*32 +: 32] = $urandom;
    in_nnz = CW'($countones(in_mask));
  endtask

  // Called at posedge+1 with data already set; returns at posedge+1 after the transfer edge.
  task automatic send();
    last_wait = 0;
    in_valid  = 1'b1;
    @(negedge clk);
    while (!in_ready && last_wait < 50) begin
      last_wait++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: decisions for the coming edge are made at negedge, when all inputs are settled.
  always @(negedge clk) begin
    if (reset_n) begin
      check("err_nnz", err_nnz, err_exp);
      if (hold_v) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_lifm", out_lifm, hold_lifm);
      end
      hold_v    = out_valid && !out_ready;
      hold_lifm = out_lifm;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1'b1, 1'b0);
        end else begin
          line_t e;
          e = exp_q.pop_front();
          check("out_lifm", out_lifm, e.lifm);
          check("out_mt", out_mt, e.mt);
          check("out_nnz", out_nnz, e.nnz);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(expand(in_mask, in_lifm, in_mt));
        if (ERR_EN && (in_nnz != CW'($countones(in_mask)))) err_exp = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0]         hist;
    logic [L*W-1:0]     saved;
    logic [4*MTW-1:0]   empty_mt;
    int                 acc;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_mask = '0; in_lifm = '0; in_mt = '0; in_nnz = '0;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_lifm", out_lifm, '0);
    check("rst_out_mt", out_mt, '0);
    check("rst_out_nnz", out_nnz, '0);
    check("rst_err", err_nnz, 1'b0);
    @(negedge clk); #1;
    reset_n = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;

    // Sparse 8-slot pattern in the low slots; packed words beyond nnz are garbage.
    @(posedge clk); #1;
    rand_line();
    in_mask = '0;
    in_mask[7:0] = 8'hA5;
    in_lifm[31:0] = 32'h4433_2211;
    in_nnz = 8'd4;
    send();
    check("t1_lat1_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    check("t1_lat2_valid", out_valid, 1'b1);
    check("t1_lifm_lo", out_lifm[63:0], 64'h4400_3300_0022_0011);
    check("t1_lifm_hi", out_lifm[L*W-1:64], '0);
    check("t1_nnz", out_nnz, 8'd4);
    empty_mt = {out_mt[6*MTW +: MTW], out_mt[4*MTW +: MTW], out_mt[3*MTW +: MTW], out_mt[1*MTW +: MTW]};
    check("t1_mt_empty", empty_mt, '0);

    // All-zero mask with all-ones garbage, then all-ones mask.
    in_mask = '0; in_lifm = '1; in_mt = '1; in_nnz = 8'd0;
    send();
    @(posedge clk); #1;
    check("t2_zero_lifm", out_lifm, '0);
    check("t2_zero_mt", out_mt, '0);
    check("t2_zero_nnz", out_nnz, 8'd0);
    rand_line();
    in_mask = '1; in_nnz = 8'd128;
    saved = in_lifm;
    send();
    @(posedge clk); #1;
    check("t2_ones_lifm", out_lifm, saved);
    check("t2_ones_nnz", out_nnz, 8'd128);

    // Four lines back to back at full rate.
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      rand_line();
      send();
      acc += last_wait;
      hist[i] = out_valid;
    end
    @(posedge clk); #1; hist[4] = out_valid;
    @(posedge clk); #1; hist[5] = out_valid;
    check("t3_stalls", acc, 0);
    check("t3_valid_train", hist, 6'b011110);

    // Output stalled while input keeps offering lines.
    out_ready = 1'b0;
    acc = 0;
    rand_line();
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
      rand_line();
    end
    check("t4_accepted", acc, 2);
    check("t4_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t4_drained", exp_q.size(), 0);

    // Asynchronous reset with two lines in flight.
    out_ready = 1'b0;
    rand_line(); send();
    rand_line(); send();
    check("t5_pre_valid", out_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_valid", out_valid, 1'b0);
    check("t5_async_lifm", out_lifm, '0);
    check("t5_async_mt", out_mt, '0);
    check("t5_async_nnz", out_nnz, '0);
    exp_q.delete();
    hold_v = 1'b0;
    err_exp = 1'b0;
    @(negedge clk); #2;
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("t5_no_stale", out_valid, 1'b0);
    end

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      rand_line();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rand_drained", exp_q.size(), 0);

    // Declared count check: matching count first, then a short count.
    rand_line();
    in_mask = '0; in_mask[3:0] = 4'hF; in_nnz = 8'd4;
    send();
    check("t6_match_err", err_nnz, 1'b0);
    rand_line();
    in_mask = '0; in_mask[3:0] = 4'hF; in_nnz = 8'd3;
    send();
    check("t6_mismatch_err", err_nnz, ERR_EN);
    repeat (3) @(posedge clk);
    #1;
    check("t6_sticky_err", err_nnz, ERR_EN);
    check("t6_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
